// File: rtl/fifo_mem_ctrl_if.sv
// Producer/consumer side of the show-ahead FIFO sequencer.
//
// Handshake rule for both channels: a word moves on a rising clk edge
// exactly when valid and ready are both high in the cycle before it.
// valid, once raised, stays up with its data stable until that transfer
// happens. ready may change freely and never waits for valid.
interface fifo_mem_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH:0]   level;

    // Environment side: the producer and the consumer.
    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, level
    );

    // Controller side.
    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, level
    );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// Sequencer that turns a dual-port memory with a 1-cycle registered read
// into a show-ahead FIFO. The memory's read register is the single output
// stage: once a word is fetched it sits on mem_read_data (= rd_data) and
// the memory holds it until the next read is issued.
//
// Capacity is DEPTH words in memory plus one in the output stage.
// Write-to-read latency is 2 cycles: the occupancy seen by the read side
// comes from registered pointers, so a word written in cycle N is fetched
// in N+1 and presented in N+2. That avoids any read-during-write bypass.
module fifo_mem_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    fifo_mem_ctrl_if.slave        bus,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  dbg_state
);

    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] PTR_ZERO  = '0;

    // EMPTY: the output stage holds nothing. VALID: rd_data is the head word.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   mem_cnt;
    logic                  wr_fire;
    logic                  fetch;
    logic                  out_valid;

    // Words still in memory. The pointers carry one extra bit so that a
    // full memory (difference DEPTH) differs from an empty one (difference 0).
    assign mem_cnt = wr_ptr - rd_ptr;

    // Full depends on the pointer registers only, so wr_ready has no
    // combinational path from rd_ready. A pop while full frees the slot
    // from the next cycle on.
    assign bus.wr_ready = (mem_cnt != DEPTH_CNT);

    // A flush cycle drops whatever the producer offers.
    assign wr_fire = bus.wr_valid & bus.wr_ready & ~flush;

    assign out_valid = (state == ST_VALID);

    // Decide whether to issue a memory read this cycle: refill an empty
    // output stage, or replace the head word while it is being taken.
    always_comb begin
        fetch = 1'b0;
        if (!flush) begin
            case (state)
                ST_EMPTY: fetch = (mem_cnt != PTR_ZERO);
                ST_VALID: fetch = bus.rd_ready && (mem_cnt != PTR_ZERO);
                default:  fetch = 1'b0;
            endcase
        end
    end

    assign mem_write_en   = wr_fire;
    assign mem_write_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign mem_write_data = bus.wr_data;

    assign mem_read_en    = fetch;
    assign mem_read_addr  = rd_ptr[ADDR_WIDTH-1:0];

    // The memory read register is the output stage, so the head word is
    // simply what the memory drives.
    assign bus.rd_valid   = out_valid;
    assign bus.rd_data    = mem_read_data;
    assign bus.level      = mem_cnt + {{ADDR_WIDTH{1'b0}}, out_valid};

    assign dbg_state      = out_valid;

    // Advance the write and read pointers; flush returns both to zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Track whether the output stage holds the head word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_EMPTY;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (mem_cnt != PTR_ZERO) begin
                        state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (bus.rd_ready && (mem_cnt == PTR_ZERO)) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Bench for fifo_mem_ctrl with a behavioural dual-port memory attached.
// The reference model is a queue of accepted words, each tagged with the
// cycle it was written in. The head is visible no earlier than two cycles
// after it was written and no earlier than one cycle after the previous pop.
module tb_fifo_mem_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic          mem_write_en;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_read_en;
    logic [AW-1:0] mem_read_addr;
    logic [DW-1:0] mem_read_data;
    logic          dbg_state;

    always #5 clk = ~clk;

    fifo_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .bus            (bus),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_read_en    (mem_read_en),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .dbg_state      (dbg_state)
    );

    // Dual-port memory: registered read, output cleared by reset.
    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) mem_read_data <= '0;
        else if (mem_read_en) mem_read_data <= mem[mem_read_addr];
    end

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] exp_q[$];
    int            wcyc_q[$];
    int            floor_c = 0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        flush        = fl;
    endtask

    task automatic clear_model();
        exp_q.delete();
        wcyc_q.delete();
        floor_c   = 0;
        wr_cnt    = 0;
        rd_cnt    = 0;
        prev_hold = 1'b0;
    endtask

    // One clock cycle: inputs are already set; check at the falling edge,
    // update the model, then step to just after the next rising edge.
    task automatic tick();
        bit e_rv;
        bit e_wr;
        int e_lvl;
        @(negedge clk);
        e_lvl = exp_q.size();
        e_rv  = (e_lvl > 0) && (cyc >= wcyc_q[0] + 2) && (cyc >= floor_c);
        e_wr  = ((e_lvl - (e_rv ? 1 : 0)) != DEPTH);
        chk("rd_valid", 32'(bus.rd_valid), 32'(e_rv));
        chk("dbg_state", 32'(dbg_state), 32'(e_rv));
        chk("level", 32'(bus.level), 32'(e_lvl));
        chk("wr_ready", 32'(bus.wr_ready), 32'(e_wr));
        if (e_rv) chk("rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
        if (prev_hold) chk("hold_stable", 32'(bus.rd_data), 32'(prev_data));
        chk("mem_write_en", 32'(mem_write_en), 32'(bus.wr_valid & e_wr & !flush));
        if (mem_write_en) chk("mem_write_addr", 32'(mem_write_addr), 32'(wr_cnt % DEPTH));
        if (mem_read_en) chk("mem_read_addr", 32'(mem_read_addr), 32'(rd_cnt % DEPTH));
        prev_hold = e_rv && !bus.rd_ready && !flush;
        if (e_rv) prev_data = exp_q[0];
        if (flush) begin
            clear_model();
        end else begin
            if (mem_read_en) rd_cnt++;
            if (e_rv && bus.rd_ready) begin
                void'(exp_q.pop_front());
                void'(wcyc_q.pop_front());
                floor_c = cyc + 1;
            end
            if (bus.wr_valid && e_wr) begin
                exp_q.push_back(bus.wr_data);
                wcyc_q.push_back(cyc);
                wr_cnt++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Assert reset mid-cycle, check the reset values, release on a falling edge.
    task automatic do_reset();
        rstn = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0);
        clear_model();
        #2;
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_mem_write_en", 32'(mem_write_en), 32'd0);
        chk("rst_mem_read_en", 32'(mem_read_en), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Idle after reset release.
        repeat (3) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            tick();
        end

        // Single word: visible two cycles after its write, then popped.
        set_in(1'b1, 8'hA5, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick();
        #1;
        chk("t2_valid", 32'(bus.rd_valid), 32'd1);
        chk("t2_data", 32'(bus.rd_data), 32'hA5);
        tick();
        #1;
        chk("t2_level", 32'(bus.level), 32'd0);
        chk("t2_empty", 32'(bus.rd_valid), 32'd0);
        tick();

        // Fill with the consumer stalled: DEPTH+1 words fit.
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            tick();
        end
        #1;
        chk("t3_level", 32'(bus.level), 32'(DEPTH + 1));
        chk("t3_wr_ready", 32'(bus.wr_ready), 32'd0);
        // Pop while full with a write offered, then drain.
        set_in(1'b1, 8'h5A, 1'b1, 1'b0);
        tick();
        #1;
        chk("t3_wr_ready_rise", 32'(bus.wr_ready), 32'd1);
        tick();
        for (int i = 0; i < 24; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            tick();
        end

        // Streaming: one write and one read per cycle, constant level.
        for (int i = 0; i < 40; i++) begin
            set_in(1'b1, 8'(i + 8'h40), 1'b1, 1'b0);
            #1;
            if (i >= 3) begin
                chk("t4_level", 32'(bus.level), 32'd2);
                chk("t4_no_bubble", 32'(bus.rd_valid), 32'd1);
            end
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            tick();
        end

        // Eight words queued, consumer ready toggling at random.
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            set_in(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            tick();
        end

        // Flush with five words queued, then one fresh word.
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("t6_valid", 32'(bus.rd_valid), 32'd0);
        chk("t6_level", 32'(bus.level), 32'd0);
        set_in(1'b1, 8'h3C, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick();
        #1;
        chk("t6_next_word", 32'(bus.rd_data), 32'h3C);
        chk("t6_next_valid", 32'(bus.rd_valid), 32'd1);
        repeat (3) tick();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
            tick();
        end

        // Reset in the middle of traffic.
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            tick();
        end
        do_reset();
        for (int i = 0; i < 60; i++) begin
            set_in(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
